// File: rtl/io_ports.sv
// I/O register block for ports B/C/D (PIN/PORT/DDR at 0x00-0x08): writes land on the clock edge, reads are zero-latency.
// Pad inputs pass a two-flop synchronizer; no backpressure, one access per cycle is always accepted.
module io_ports #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic                     write_enable,
  input  logic [DATA_WIDTH-1:0]    write_data,
  output logic [DATA_WIDTH-1:0]    read_data,
  input  logic [DATA_WIDTH-1:0]    pin_b_in,
  input  logic [DATA_WIDTH-1:0]    pin_c_in,
  input  logic [DATA_WIDTH-1:0]    pin_d_in,
  output logic [DATA_WIDTH-1:0]    pad_b_out,
  output logic [DATA_WIDTH-1:0]    pad_c_out,
  output logic [DATA_WIDTH-1:0]    pad_d_out,
  output logic [DATA_WIDTH-1:0]    pad_b_oe,
  output logic [DATA_WIDTH-1:0]    pad_c_oe,
  output logic [DATA_WIDTH-1:0]    pad_d_oe
);

  localparam int NPORT = 3;

  typedef enum logic [1:0] {SEL_PIN, SEL_PORT, SEL_DDR, SEL_NONE} sel_e;

  sel_e       sel;
  logic [1:0] sel_port;

  logic [DATA_WIDTH-1:0] pin_in  [NPORT];
  logic [DATA_WIDTH-1:0] port_q  [NPORT];
  logic [DATA_WIDTH-1:0] port_d  [NPORT];
  logic [DATA_WIDTH-1:0] ddr_q   [NPORT];
  logic [DATA_WIDTH-1:0] ddr_d   [NPORT];
  logic [DATA_WIDTH-1:0] sync1_q [NPORT];
  logic [DATA_WIDTH-1:0] sync1_d [NPORT];
  logic [DATA_WIDTH-1:0] sync2_q [NPORT];
  logic [DATA_WIDTH-1:0] sync2_d [NPORT];

  assign pin_in[0] = pin_b_in;
  assign pin_in[1] = pin_c_in;
  assign pin_in[2] = pin_d_in;

  // Each port occupies three consecutive addresses: PIN, PORT, DDR.
  always_comb begin
    sel      = SEL_NONE;
    sel_port = 2'd0;
    case (address)
      ADDRESS_WIDTH'(0): begin sel = SEL_PIN;  sel_port = 2'd0; end
      ADDRESS_WIDTH'(1): begin sel = SEL_PORT; sel_port = 2'd0; end
      ADDRESS_WIDTH'(2): begin sel = SEL_DDR;  sel_port = 2'd0; end
      ADDRESS_WIDTH'(3): begin sel = SEL_PIN;  sel_port = 2'd1; end
      ADDRESS_WIDTH'(4): begin sel = SEL_PORT; sel_port = 2'd1; end
      ADDRESS_WIDTH'(5): begin sel = SEL_DDR;  sel_port = 2'd1; end
      ADDRESS_WIDTH'(6): begin sel = SEL_PIN;  sel_port = 2'd2; end
      ADDRESS_WIDTH'(7): begin sel = SEL_PORT; sel_port = 2'd2; end
      ADDRESS_WIDTH'(8): begin sel = SEL_DDR;  sel_port = 2'd2; end
      default: ;
    endcase
  end

  always_comb begin
    read_data = '0;
    for (int i = 0; i < NPORT; i++) begin
      port_d[i]  = port_q[i];
      ddr_d[i]   = ddr_q[i];
      sync1_d[i] = pin_in[i];
      sync2_d[i] = sync1_q[i];
      if (sel_port == 2'(i)) begin
        case (sel)
          SEL_PIN: begin
            read_data = sync2_q[i];
            // A PIN write toggles the output latch; the synchronizer is read-only.
            if (write_enable) port_d[i] = port_q[i] ^ write_data;
          end
          SEL_PORT: begin
            read_data = port_q[i];
            if (write_enable) port_d[i] = write_data;
          end
          SEL_DDR: begin
            read_data = ddr_q[i];
            if (write_enable) ddr_d[i] = write_data;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPORT; i++) begin
        port_q[i]  <= '0;
        ddr_q[i]   <= '0;
        sync1_q[i] <= '0;
        sync2_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        port_q[i]  <= port_d[i];
        ddr_q[i]   <= ddr_d[i];
        sync1_q[i] <= sync1_d[i];
        sync2_q[i] <= sync2_d[i];
      end
    end
  end

  assign pad_b_out = port_q[0] & ddr_q[0];
  assign pad_c_out = port_q[1] & ddr_q[1];
  assign pad_d_out = port_q[2] & ddr_q[2];
  assign pad_b_oe  = ddr_q[0];
  assign pad_c_oe  = ddr_q[1];
  assign pad_d_oe  = ddr_q[2];

endmodule

// File: doc/io_ports.md
# io_ports

Memory-mapped I/O register block for I/O ports B, C and D, addressed by the I/O addresses PINB..DDRD (0x00–0x08). It sits directly downstream of the control unit's EXECUTE state. OUT instructions write PORTx/DDRx/PINx here; IN instructions read back register contents and synchronized pad levels. External pad inputs pass through a two-flop synchronizer before they are visible to the CPU.

## Interface
Parameters:
- DATA_WIDTH, 8, width of every I/O register and of each port
- ADDRESS_WIDTH, 8, width of the I/O address bus

Ports:
- clock  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- address  in  ADDRESS_WIDTH  I/O register address (PINB=0x00 … DDRD=0x08)
- write_enable  in  1  write strobe from the EXECUTE state of an OUT instruction
- write_data  in  DATA_WIDTH  data to write
- read_data  out  DATA_WIDTH  combinational read of the addressed register
- pin_b_in, pin_c_in, pin_d_in  in  DATA_WIDTH each  raw asynchronous pad levels
- pad_b_out, pad_c_out, pad_d_out  out  DATA_WIDTH each  driven pad value, equal to PORTx & DDRx
- pad_b_oe, pad_c_oe, pad_d_oe  out  DATA_WIDTH each  per-bit output enable, equal to DDRx

## Operation
- Storage per port x ∈ {B,C,D}:
  - PORTx register.
  - DDRx register.
  - sync1_x and sync2_x flops, each DATA_WIDTH bits.
- Synchronizer, every clock: sync1_x <= pin_x_in; sync2_x <= sync1_x. PINx reads return sync2_x, regardless of DDRx.
- Write (write_enable=1), decoded on address:
  - PORTx address: PORTx <= write_data.
  - DDRx address: DDRx <= write_data.
  - PINx address: PORTx <= PORTx ^ write_data. This toggles the bits written as 1; PINx itself is not writable.
  - Address > 0x08: write ignored, no register changes.
- Read, always active and independent of write_enable:
  - read_data = PINx / PORTx / DDRx per address.
  - Address > 0x08: read_data = 0.
- A write and a read of the same register in the same cycle: read_data shows the old value. The new value is visible from the cycle after the edge.
- Outputs:
  - pad_x_out = PORTx & DDRx, so bits configured as inputs drive 0.
  - pad_x_oe = DDRx.
  - Both are purely combinational from registers.
- Reset (asynchronous, any time, including mid-write): PORTx, DDRx, sync1_x and sync2_x all go to 0 immediately. Consequently:
  - all pad_x_out = 0 and pad_x_oe = 0 (all pins inputs);
  - read_data = 0 for every valid address while reset is held.
- Only one address per cycle, so ports never have simultaneous-access conflicts.

## Timing
- Write latency: a register updates on the rising edge where write_enable=1. pad outputs change in the same cycle, right after that edge.
- Read latency: zero cycles, combinational from register state.
- Pin-to-read latency: a pad level stable before edge k is captured in sync1 at k and in sync2 at k+1. It is readable via PINx after edge k+1, i.e. 2 edges.
- A pulse shorter than one clock period may be missed; this is acceptable.
- Reset release: registers start updating at the first rising edge after reset deasserts. The synchronizer needs 2 edges before PINx reflects the pads.

## Test plan
- Reset: assert reset with pins at 0xFF. Required: every pad_x_out/pad_x_oe = 0x00 and read_data at 0x00, 0x01 and 0x02 = 0x00. Release reset and wait 2 edges. Required: read of PINB = 0xFF.
- Output path: write DDRB=0x0F, then PORTB=0xFF. Required: pad_b_oe=0x0F, pad_b_out=0x0F, read PORTB=0xFF, read DDRB=0x0F.
- Toggle: with PORTC=0xA5, write 0x0F to PINC (0x03). Required: PORTC=0xAA. Then write 0x00 to PINC. Required: PORTC unchanged at 0xAA.
- Synchronizer latency: change pin_d_in 0x00→0x3C just after an edge. Required: PIND reads 0x00 after the first edge and 0x3C after the second edge.
- Invalid address: write 0x55 to address 0x09. Required: no register changes, and read_data at 0x09 and 0xFF = 0x00.
- Mid-operation reset: assert reset asynchronously in the same cycle as a write of 0xFF to DDRD. Required: DDRD = 0x00 immediately and 0x00 after reset release, i.e. the write is lost.
